// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite signal bundle between the bus mux/master side and the SRAM slave.
interface ahb_lite_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HBURST, HWDATA,
    input  HREADY, HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HBURST, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite word SRAM slave with byte-lane writes and two-cycle ERROR responses.
// Define AHB_SRAM_WAIT_EN to compile in WAIT_CYCLES wait states per transfer.
module ahb_lite_sram_slave #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  ahb_lite_sram_slave_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** (ADDR_W - 2);

`ifdef AHB_SRAM_WAIT_EN
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;
`endif

  state_t              state;
  state_t              samp_state;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [1:0]          size_q;
  logic                err_q;
  logic                hreadyout_q;
  logic                hresp_q;
  logic                samp_ready;
  logic                samp_resp;
  logic                sample;
  logic                addr_err;
  logic                rd_phase;
  logic [3:0]          be;
  logic [ADDR_W-3:0]   widx;
  logic [31:0]         rdata;
  logic [31:0]         mem [DEPTH];
  logic                unused_ok;

`ifdef AHB_SRAM_WAIT_EN
  logic [3:0]          cnt;
`endif

  assign sample   = bus.HSEL && bus.HREADY && bus.HTRANS[1];
  assign addr_err = (bus.HSIZE > 3'd2)
                 || (bus.HSIZE == 3'd1 && bus.HADDR[0])
                 || (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00)
                 || (bus.HADDR[29:ADDR_W] != '0);
  assign widx     = addr_q[ADDR_W-1:2];

`ifdef AHB_SRAM_WAIT_EN
  assign rd_phase = (state == ST_DATA) || (state == ST_WAIT);
  assign unused_ok = ^{bus.HBURST, bus.HADDR[31:30]};
`else
  assign rd_phase = (state == ST_DATA);
  assign unused_ok = ^{bus.HBURST, bus.HADDR[31:30], 4'(WAIT_CYCLES)};
`endif

  // Destination and registered outputs for a fresh address-phase sample.
  always_comb begin
    samp_state = ST_DATA;
    samp_ready = 1'b1;
    samp_resp  = 1'b0;
    if (addr_err) begin
      samp_state = ST_ERR1;
      samp_ready = 1'b0;
      samp_resp  = 1'b1;
    end
`ifdef AHB_SRAM_WAIT_EN
    else if (WAIT_CYCLES != 0) begin
      samp_state = ST_WAIT;
      samp_ready = 1'b0;
    end
`endif
  end

  always_comb begin
    be = '0;
    case (size_q)
      2'd0:    be[addr_q[1:0]] = 1'b1;
      2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state       <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= '0;
      err_q       <= 1'b0;
`ifdef AHB_SRAM_WAIT_EN
      cnt         <= '0;
`endif
    end else begin
      case (state)
`ifdef AHB_SRAM_WAIT_EN
        ST_WAIT: begin
          if (cnt <= 4'd1) begin
            state       <= ST_DATA;
            hreadyout_q <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
`endif
        ST_ERR1: begin
          state       <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all end on a cycle where a new address may be taken.
          if (sample) begin
            state       <= samp_state;
            hreadyout_q <= samp_ready;
            hresp_q     <= samp_resp;
            addr_q      <= bus.HADDR[ADDR_W-1:0];
            write_q     <= bus.HWRITE;
            size_q      <= bus.HSIZE[1:0];
            err_q       <= addr_err;
`ifdef AHB_SRAM_WAIT_EN
            cnt         <= (samp_state == ST_WAIT) ? 4'(WAIT_CYCLES) : '0;
`endif
          end else begin
            state       <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET && state == ST_DATA && write_q && !err_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_phase && !write_q && !err_q) rdata = mem[widx];
  end

  assign bus.HRDATA    = rdata;
  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Randomized scoreboard bench for ahb_lite_sram_slave with a byte-lane memory model.
module tb_ahb_lite_sram_slave;

`ifdef AHB_SRAM_WAIT_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif

  typedef struct {
    logic        wr;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] addr;
  } exp_t;

  logic HCLK = 1'b0;
  logic HRESET;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];
  logic [31:0] mdl [256];

  ahb_lite_sram_slave_if bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_lite_sram_slave #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic is_err(input logic [31:0] a, input logic [2:0] sz);
    return (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00)
        || (a[29:10] != 20'd0);
  endfunction

  // Drives one address phase, waits for acceptance, records the expected response,
  // then presents this transfer's write data for its data phase.
  task automatic issue(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                       input logic wr, input logic [2:0] sz, input logic [31:0] wd);
    int   guard = 0;
    exp_t e;
    int   off;
    bus.HSEL = sel; bus.HTRANS = tr; bus.HADDR = a; bus.HWRITE = wr;
    bus.HSIZE = sz; bus.HBURST = 3'b001;
    @(negedge HCLK);
    while (!bus.HREADYOUT && guard < 40) begin
      guard++;
      @(negedge HCLK);
    end
    if (guard >= 40) begin
      checks++; errors++;
      $display("FAIL accept_timeout: HREADYOUT stuck at %b, required 1", bus.HREADYOUT);
    end
    if (sel && tr[1]) begin
      e.wr = wr; e.addr = a; e.err = is_err(a, sz);
      e.rdata = (e.err || wr) ? 32'h0 : mdl[a[9:2]];
      if (!e.err && wr) begin
        if (sz == 3'd0) begin
          off = int'(a[1:0]);
          mdl[a[9:2]][8*off +: 8] = wd[8*off +: 8];
        end else if (sz == 3'd1) begin
          off = a[1] ? 2 : 0;
          mdl[a[9:2]][8*off +: 16] = wd[8*off +: 16];
        end else begin
          mdl[a[9:2]] = wd;
        end
      end
      sb.push_back(e);
    end
    @(posedge HCLK); #1;
    bus.HWDATA = wd;
  endtask

  task automatic drain();
    int guard = 0;
    issue(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 32'h0);
    while (sb.size() != 0 && guard < 60) begin
      guard++;
      @(posedge HCLK); #1;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: follows data phases on the bus and scores each completion.
  initial begin
    bit   pend = 1'b0;
    int   low = 0;
    int   low_resp = 0;
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (HRESET || !mon_en) begin
        pend = 1'b0; low = 0; low_resp = 0;
        continue;
      end
      if (pend) begin
        if (!bus.HREADYOUT) begin
          low++;
          if (bus.HRESP) low_resp++;
          if (low > 40) begin
            checks++; errors++;
            $display("FAIL data_timeout: HREADYOUT low %0d cycles, required at most 40", low);
            if (sb.size() != 0) void'(sb.pop_front());
            pend = 1'b0; low = 0; low_resp = 0;
          end
        end else if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: completion seen, required none");
          pend = 1'b0; low = 0; low_resp = 0;
        end else begin
          e = sb.pop_front();
          chk($sformatf("hresp@%h", e.addr), 32'(bus.HRESP), 32'(e.err));
          chk($sformatf("low_cycles@%h", e.addr), 32'(low), e.err ? 32'd1 : 32'(EXP_WAIT));
          chk($sformatf("low_resp@%h", e.addr), 32'(low_resp), e.err ? 32'd1 : 32'd0);
          chk($sformatf("hrdata@%h", e.addr), bus.HRDATA, e.rdata);
          pend = 1'b0; low = 0; low_resp = 0;
        end
      end
      if (bus.HSEL && bus.HREADY && bus.HTRANS[1]) pend = 1'b1;
    end
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    logic [1:0]  tr;
    logic        s;
    bus.HSEL = 1'b0; bus.HADDR = '0; bus.HWRITE = 1'b0; bus.HSIZE = '0;
    bus.HTRANS = 2'b00; bus.HBURST = '0; bus.HWDATA = '0;
    HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    chk("reset_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("reset_hresp", 32'(bus.HRESP), 32'd0);
    chk("reset_hrdata", bus.HRDATA, 32'h0);
    @(posedge HCLK); #1;
    mon_en = 1'b1;

    for (int i = 0; i < 256; i++) issue(1'b1, 2'b10, 32'(i * 4), 1'b1, 3'd2, $urandom());

    issue(1'b1, 2'b10, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
    issue(1'b1, 2'b10, 32'h10, 1'b0, 3'd2, 32'h0);
    issue(1'b1, 2'b10, 32'h13, 1'b1, 3'd0, 32'hAA000000);
    issue(1'b1, 2'b10, 32'h10, 1'b0, 3'd2, 32'h0);
    issue(1'b1, 2'b10, 32'h11, 1'b1, 3'd1, 32'h12345678);
    issue(1'b1, 2'b10, 32'h10, 1'b0, 3'd2, 32'h0);
    issue(1'b1, 2'b10, 32'h400, 1'b0, 3'd2, 32'h0);
    issue(1'b1, 2'b10, 32'h20, 1'b1, 3'd2, 32'd1);
    issue(1'b1, 2'b11, 32'h24, 1'b1, 3'd2, 32'd2);
    issue(1'b1, 2'b11, 32'h28, 1'b1, 3'd2, 32'd3);
    issue(1'b1, 2'b10, 32'h20, 1'b0, 3'd2, 32'h0);
    issue(1'b1, 2'b11, 32'h24, 1'b0, 3'd2, 32'h0);
    issue(1'b1, 2'b11, 32'h28, 1'b0, 3'd2, 32'h0);
    drain();
    chk("model_0x10", mdl[4], 32'hAAADBEEF);

    // Reset in the middle of a write data phase must not commit it.
    mon_en = 1'b0;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h24; bus.HWRITE = 1'b1; bus.HSIZE = 3'd2;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = 32'h55;
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("midreset_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("midreset_hresp", 32'(bus.HRESP), 32'd0);
    chk("midreset_hrdata", bus.HRDATA, 32'h0);
    @(posedge HCLK); #1;
    mon_en = 1'b1;
    issue(1'b1, 2'b10, 32'h24, 1'b0, 3'd2, 32'h0);
    drain();

    for (int n = 0; n < 400; n++) begin
      sz = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) sz = 3'($urandom_range(3, 7));
      a = $urandom() & 32'h3FF;
      a[31:30] = 2'($urandom());
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 3'd1) a[0] = 1'b0;
        if (sz == 3'd2) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 15) == 0) a[10 + $urandom_range(0, 19)] = 1'b1;
      tr = ($urandom_range(0, 7) < 2) ? 2'($urandom_range(0, 1)) : ((n % 2 == 1) ? 2'b11 : 2'b10);
      s = ($urandom_range(0, 7) != 0);
      issue(s, tr, a, 1'($urandom()), sz, $urandom());
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
